// File: rtl/mem_arb_pkg.sv
`default_nettype none
// mem_arb_pkg: state encoding and port indices shared by the memory port arbiter.
// Revision: 1.0
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_WDATA   = 3'd2,
        ST_ACCESS  = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_RELEASE = 3'd5
    } arb_state_t;

    localparam int PORT_CPU = 0;
    localparam int PORT_DMA = 1;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// rr_arb2: combinational two-way arbiter, fixed CPU priority or round-robin.
// Revision: 1.0
module rr_arb2
    import mem_arb_pkg::*;
#(
    parameter int CPU_PRIO = 1
) (
    input  logic [1:0] req_i,
    input  logic       rr_last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[PORT_CPU] && req_i[PORT_DMA]) begin
            // On a tie the CPU wins outright, or whenever the DMA port went last.
            if ((CPU_PRIO != 0) || rr_last_i) begin
                gnt_o[PORT_CPU] = 1'b1;
            end else begin
                gnt_o[PORT_DMA] = 1'b1;
            end
        end else if (req_i[PORT_CPU]) begin
            gnt_o[PORT_CPU] = 1'b1;
        end else if (req_i[PORT_DMA]) begin
            gnt_o[PORT_DMA] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: shares the MAR/MDR memory port between the CPU FSM and the DMA engine.
// Revision: 1.0
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int TIMEOUT  = 255,
    parameter int CPU_PRIO = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [1:0]        err,
    output logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              LD_MAR,
    output logic              LD_MDR,
    output logic              MIO_EN,
    output logic              R_W,
    output logic              GateMDR,
    input  logic              R
);

    localparam int CNT_W = 16;

    arb_state_t        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rr_last_q, rr_last_d;
    logic              wdone_q, wdone_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        win_gnt;
    logic              sel_dma;

    rr_arb2 #(
        .CPU_PRIO (CPU_PRIO)
    ) u_rr_arb2 (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .gnt_o     (win_gnt)
    );

    assign sel_dma = win_gnt[PORT_DMA];
    assign gnt     = gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 2'b00;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rr_last_q <= 1'b1;
            wdone_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rr_last_q <= rr_last_d;
            wdone_q   <= wdone_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rr_last_d = rr_last_q;
        wdone_d   = 1'b0;
        cnt_d     = '0;
        bus_out   = '0;
        bus_oe    = 1'b0;
        LD_MAR    = 1'b0;
        LD_MDR    = 1'b0;
        MIO_EN    = 1'b0;
        R_W       = 1'b0;
        GateMDR   = 1'b0;
        done      = 2'b00;
        err       = 2'b00;
        rdata     = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    gnt_d     = win_gnt;
                    we_d      = sel_dma ? we[PORT_DMA] : we[PORT_CPU];
                    addr_d    = sel_dma ? addr1 : addr0;
                    wdata_d   = sel_dma ? wdata1 : wdata0;
                    rr_last_d = sel_dma;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus_out = DATA_W'(addr_q);
                bus_oe  = 1'b1;
                LD_MAR  = 1'b1;
                state_d = we_q ? ST_WDATA : ST_ACCESS;
            end
            ST_WDATA: begin
                bus_out = wdata_q;
                bus_oe  = 1'b1;
                LD_MDR  = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                MIO_EN = 1'b1;
                R_W    = we_q;
                LD_MDR = ~we_q;
                cnt_d  = cnt_q + 1'b1;
                if (R) begin
                    wdone_d = we_q;
                    state_d = we_q ? ST_RELEASE : ST_CAPTURE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    err     = gnt_q;
                    state_d = ST_RELEASE;
                end
            end
            ST_CAPTURE: begin
                // Bypass so the read value is already visible in the done cycle.
                GateMDR = 1'b1;
                rdata_d = bus_in;
                rdata   = bus_in;
                done    = gnt_q;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                done    = wdone_q ? gnt_q : 2'b00;
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single memory/MMIO port (MAR/MDR, MIO_EN, R_W, ready R) between two requesters: the CPU control FSM (port 0) and the I2C/DMA engine (port 1).
- Converts a simple req/addr/wdata/we transaction into the bus load, gate and enable sequence.
- Waits on the port ready flag and returns read data plus a one-cycle done pulse.
- Sits between the control unit and the memory subsystem, and owns the shared 16-bit bus while it holds a grant.

Parameters:
- ADDR_W, 16, address width (matches MAR)
- DATA_W, 16, data width (matches MDR/bus)
- TIMEOUT, 255, max cycles waiting for R before abort; 0 disables the timeout
- CPU_PRIO, 1, 1 = port 0 wins every tie; 0 = round-robin between ports

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- req  in  2  per-port request, held until done or err
- we  in  2  per-port write enable (1 = write, 0 = read), sampled at grant
- addr0, addr1  in  ADDR_W each  per-port address, sampled at grant
- wdata0, wdata1  in  DATA_W each  per-port write data, sampled at grant
- gnt  out  2  one-hot grant, held for the whole transaction
- done  out  2  one-cycle completion pulse per port
- err  out  2  one-cycle timeout pulse per port
- rdata  out  DATA_W  read data, valid in the done cycle, held until the next read completes
- bus_in  in  DATA_W  shared bus value (MDR as driven by GateMDR)
- bus_out  out  DATA_W  value this block drives onto the bus
- bus_oe  out  1  bus drive enable
- LD_MAR, LD_MDR, MIO_EN, R_W, GateMDR  out  1 each  memory port controls
- R  in  1  memory port ready

Behaviour:
- Reset: state=IDLE; gnt, done, err, bus_oe, and all memory controls = 0; rdata=0; rr_last=1 (port 0 favoured first); timeout counter cleared.
- States: IDLE -> ADDR -> (WDATA if write) -> ACCESS -> (CAPTURE if read) -> RELEASE -> IDLE.
- IDLE:
  - Arbitrate across the asserted req bits.
  - Single requester: granted.
  - Both with CPU_PRIO=1: port 0.
  - Both with CPU_PRIO=0: the port not in rr_last; rr_last updates at grant.
  - Latch we/addr/wdata of the winner and set gnt. Next state ADDR.
- ADDR (1 cycle): bus_out=addr, bus_oe=1, LD_MAR=1.
- WDATA (1 cycle, writes only): bus_out=wdata, bus_oe=1, LD_MDR=1, MIO_EN=0.
- ACCESS:
  - MIO_EN=1; R_W=latched we; LD_MDR=1 for reads; bus_oe=0.
  - Counter increments each cycle.
  - On R=1: read -> CAPTURE; write -> RELEASE with done pulse.
  - Counter reaching TIMEOUT with R=0: err pulse, go to RELEASE.
- CAPTURE (1 cycle): MIO_EN=0, GateMDR=1, rdata<=bus_in, done pulse.
- RELEASE (1 cycle):
  - All controls 0, so the port clears R (it needs MIO_EN=0 for one edge).
  - gnt drops at the end of this cycle.
  - No new grant is issued in this cycle.
- Latency:
  - Write = 4 cycles grant-to-done plus memory wait.
  - Read = ADDR + ACCESS (>=1) + CAPTURE, so done arrives at the earliest in the 3rd cycle after grant.
- Request rules:
  - req deasserted mid-transaction is ignored; the transaction completes.
  - A req still high after done is treated as a new request (back-to-back allowed after RELEASE).
- Bus exclusivity: bus_oe and GateMDR are never both 1. No memory control is asserted while gnt=0.
- rst mid-transaction: immediate return to IDLE and all outputs to reset values; no done or err pulse.
- done and err are never asserted in the same cycle.

Decomposition:
- Shared package mem_arb_pkg:
  - state encoding constants (IDLE..RELEASE, 3 bits)
  - port index constants (PORT_CPU=0, PORT_DMA=1)
- Sub-module rr_arb2: 2-way arbiter, priority/round-robin selectable.
  - Inputs: req, rr_last, CPU_PRIO.
  - Output: one-hot grant.
  - Purely combinational; rr_last is registered in the parent.

Test Plan:
- Write, port 0 only:
  - Stimulus: req=01, we0=1, addr0=16'h3000, wdata0=16'hBEEF; R rises 2 cycles into ACCESS.
  - Required: LD_MAR with bus_out=3000, then LD_MDR with BEEF, then MIO_EN=1/R_W=1; done0 pulses once; gnt clears after RELEASE.
- Read, port 1 only:
  - Stimulus: req=10, addr1=16'hFE02; model returns bus_in=16'h0041 when GateMDR=1.
  - Required: rdata=0041 in the done1 cycle; R_W=0 throughout.
- Tie-break:
  - Stimulus: req=11 held continuously.
  - Required with CPU_PRIO=1: grant order 0,0,0.
  - Required with CPU_PRIO=0: grant order 0,1,0,1; never two grants at once.
- Timeout:
  - Stimulus: TIMEOUT=4, R held 0.
  - Required: err pulses at the 4th ACCESS cycle, no done, return to IDLE via RELEASE.
- Reset mid-ACCESS:
  - Stimulus: rst=1 for 1 cycle.
  - Required: all outputs 0 the next cycle; rdata=0; the next request proceeds normally.
- Bus safety (checked across all tests): bus_oe & GateMDR never both 1; MIO_EN=0 whenever gnt=00.
